// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 register-file constants and writeback entry type
package legv8_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam int XZR_IDX    = 31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - in-order result queue exposing every entry oldest-first
module wb_result_fifo #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [ADDR_W-1:0]              push_rd_i,
  input  logic [DATA_W-1:0]              push_data_i,
  input  logic                           pop_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [DEPTH-1:0]               ord_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ord_rd_o,
  output logic [DEPTH-1:0][DATA_W-1:0]   ord_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_q[wr_ptr_q]   <= push_rd_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    ord_valid_o = '0;
    ord_rd_o    = '0;
    ord_data_o  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ord_valid_o[k] = (CNT_W'(k) < count_q);
      ord_rd_o[k]    = rd_q[rd_ptr_q + PTR_W'(k)];
      ord_data_o[k]  = data_q[rd_ptr_q + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - arbitrates ALU/load results into the register file write port
module reg_writeback_unit
  import legv8_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = XZR_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_hold,
  output logic              REG_WRITE,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] look_a_rd,
  output logic              look_a_hit,
  output logic [DATA_W-1:0] look_a_data,
  input  logic [ADDR_W-1:0] look_b_rd,
  output logic              look_b_hit,
  output logic [DATA_W-1:0] look_b_data,
  output logic              wb_empty
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(ZERO_REG);

  logic                         full, empty;
  logic                         mem_fire, alu_fire, push, pop;
  logic [ADDR_W-1:0]            sel_rd;
  logic [DATA_W-1:0]            sel_data;
  logic [DEPTH-1:0]             ord_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ord_rd;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;

  // Load wins a collision; ready is based on occupancy before this cycle's pop.
  assign mem_ready = rst_n & ~full;
  assign alu_ready = rst_n & ~full & ~mem_valid;
  assign mem_fire  = mem_valid & mem_ready;
  assign alu_fire  = alu_valid & alu_ready;
  assign sel_rd    = mem_fire ? mem_rd   : alu_rd;
  assign sel_data  = mem_fire ? mem_data : alu_data;
  assign push      = (mem_fire | alu_fire) & (sel_rd != XZR);

  assign REG_WRITE = rst_n & ~empty & ~wb_hold;
  assign pop       = REG_WRITE;
  assign write_reg = (rst_n & ~empty) ? ord_rd[0]   : '0;
  assign writeData = (rst_n & ~empty) ? ord_data[0] : '0;
  assign wb_empty  = ~rst_n | empty;

  wb_result_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_rd_i   (sel_rd),
    .push_data_i (sel_data),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .ord_valid_o (ord_valid),
    .ord_rd_o    (ord_rd),
    .ord_data_o  (ord_data)
  );

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    look_a_hit  = 1'b0;
    look_a_data = '0;
    look_b_hit  = 1'b0;
    look_b_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rst_n && ord_valid[k] && ord_rd[k] == look_a_rd && look_a_rd != XZR) begin
        look_a_hit  = 1'b1;
        look_a_data = ord_data[k];
      end
      if (rst_n && ord_valid[k] && ord_rd[k] == look_b_rd && look_b_rd != XZR) begin
        look_b_hit  = 1'b1;
        look_b_data = ord_data[k];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - self-checking bench for reg_writeback_unit
module tb_reg_writeback_unit;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0, mem_valid = 1'b0, wb_hold = 1'b0;
  logic [AW-1:0] alu_rd = '0, mem_rd = '0, look_a_rd = '0, look_b_rd = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready, REG_WRITE, look_a_hit, look_b_hit, wb_empty;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] writeData, look_a_data, look_b_data;

  reg_writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_hold(wb_hold), .REG_WRITE(REG_WRITE), .write_reg(write_reg), .writeData(writeData),
    .look_a_rd(look_a_rd), .look_a_hit(look_a_hit), .look_a_data(look_a_data),
    .look_b_rd(look_b_rd), .look_b_hit(look_b_hit), .look_b_data(look_b_data),
    .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] file_img[32];
  int            wlog[$];
  int            nwrites = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain list of pending writes, updated once per edge.
  always @(posedge clk) begin
    bit   acc;
    ent_t e;
    acc = 1'b0;
    e.rd = '0;
    e.data = '0;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (q.size() < D) begin
        if (mem_valid) begin
          e.rd = mem_rd; e.data = mem_data; acc = 1'b1;
        end else if (alu_valid) begin
          e.rd = alu_rd; e.data = alu_data; acc = 1'b1;
        end
      end
      if (q.size() != 0 && !wb_hold) void'(q.pop_front());
      if (acc && e.rd != 5'd31) q.push_back(e);
    end
  end

  // Per-cycle comparison against the model, plus a record of issued writes.
  always @(negedge clk) begin
    bit            e_hit_a, e_hit_b, nonempty;
    logic [DW-1:0] e_dat_a, e_dat_b;
    nonempty = rst_n && q.size() != 0;
    e_hit_a = 1'b0; e_hit_b = 1'b0; e_dat_a = '0; e_dat_b = '0;
    if (rst_n) begin
      foreach (q[i]) begin
        if (q[i].rd == look_a_rd && look_a_rd != 5'd31) begin e_hit_a = 1'b1; e_dat_a = q[i].data; end
        if (q[i].rd == look_b_rd && look_b_rd != 5'd31) begin e_hit_b = 1'b1; e_dat_b = q[i].data; end
      end
    end
    chk("mem_ready", mem_ready, rst_n && q.size() < D);
    chk("alu_ready", alu_ready, rst_n && q.size() < D && !mem_valid);
    chk("REG_WRITE", REG_WRITE, nonempty && !wb_hold);
    chk("write_reg", write_reg, nonempty ? q[0].rd : '0);
    chk("writeData", writeData, nonempty ? q[0].data : '0);
    chk("wb_empty", wb_empty, !nonempty);
    chk("look_a_hit", look_a_hit, e_hit_a);
    chk("look_a_data", look_a_data, e_dat_a);
    chk("look_b_hit", look_b_hit, e_hit_b);
    chk("look_b_data", look_b_data, e_dat_b);
    if (REG_WRITE === 1'b1) begin
      file_img[write_reg] = writeData;
      wlog.push_back(int'(write_reg));
      nwrites++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    foreach (file_img[i]) file_img[i] = '0;
    step(); step();
    @(negedge clk);
    chk("rst_REG_WRITE", REG_WRITE, 1'b0);
    chk("rst_wb_empty", wb_empty, 1'b1);
    chk("rst_alu_ready", alu_ready, 1'b0);
    rst_n = 1'b1;

    // single ALU result
    step();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
    @(negedge clk);
    chk("t2_alu_ready", alu_ready, 1'b1);
    chk("t2_no_write_yet", REG_WRITE, 1'b0);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t2_REG_WRITE", REG_WRITE, 1'b1);
    chk("t2_write_reg", write_reg, 5'd5);
    chk("t2_writeData", writeData, 64'hDEAD);
    step();
    @(negedge clk);
    chk("t2_empty_after", wb_empty, 1'b1);

    // collision: load first
    step();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h22;
    @(negedge clk);
    chk("t3_alu_ready", alu_ready, 1'b0);
    chk("t3_mem_ready", mem_ready, 1'b1);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("t3_first_reg", write_reg, 5'd4);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t3_second_reg", write_reg, 5'd3);
    chk("t3_second_data", writeData, 64'h11);
    step(); step();
    chk("t3_log_order", {wlog[wlog.size()-2][7:0], wlog[wlog.size()-1][7:0]}, 16'h0403);

    // XZR discard
    mem_valid = 1'b1; mem_rd = 5'd31; mem_data = 64'hFF; look_a_rd = 5'd31;
    @(negedge clk);
    chk("t4_mem_ready", mem_ready, 1'b1);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("t4_no_write", REG_WRITE, 1'b0);
    chk("t4_hit", look_a_hit, 1'b0);
    chk("t4_empty", wb_empty, 1'b1);

    // full under hold, then drain
    step();
    wb_hold = 1'b1; look_a_rd = 5'd2;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(i); alu_data = 64'h100 + 64'(i);
      @(negedge clk);
      chk("t5_accept", alu_ready, 1'b1);
      step();
    end
    alu_rd = 5'd5; alu_data = 64'h105;
    @(negedge clk);
    chk("t5_full_alu_ready", alu_ready, 1'b0);
    chk("t5_full_mem_ready", mem_ready, 1'b0);
    chk("t5_look_hit", look_a_hit, 1'b1);
    chk("t5_look_data", look_a_data, 64'h102);
    step();
    alu_valid = 1'b0; wb_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t5_drain_we", REG_WRITE, 1'b1);
      chk("t5_drain_reg", write_reg, AW'(i));
      step();
    end
    @(negedge clk);
    chk("t5_empty", wb_empty, 1'b1);

    // forwarding of youngest value
    step();
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hA;
    step();
    alu_data = 64'hB;
    step();
    alu_valid = 1'b0; look_b_rd = 5'd7;
    @(negedge clk);
    chk("t6_look_b_hit", look_b_hit, 1'b1);
    chk("t6_look_b_data", look_b_data, 64'hB);
    step();
    wb_hold = 1'b0;
    step(); step(); step();
    chk("t6_file_r7", file_img[7], 64'hB);

    // reset with queued entries
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    step();
    alu_rd = 5'd10; alu_data = 64'hAA;
    step();
    alu_valid = 1'b0; look_a_rd = 5'd9;
    @(negedge clk);
    chk("t1_pre_hit", look_a_hit, 1'b1);
    step();
    rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    chk("t1_REG_WRITE", REG_WRITE, 1'b0);
    chk("t1_wb_empty", wb_empty, 1'b1);
    chk("t1_hit", look_a_hit, 1'b0);
    step();
    rst_n = 1'b1; wb_hold = 1'b0;
    n0 = nwrites;
    step(); step(); step();
    @(negedge clk);
    chk("t1_empty_after", wb_empty, 1'b1);
    chk("t1_no_writes", 64'(nwrites), 64'(n0));

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
